// File: rtl/dmem_pkg.sv
// dmem_pkg: shared state encoding and byte-enable constants for dmem_ctrl
package dmem_pkg;
  typedef enum logic [1:0] {
    IDLE = 2'b00,
    BUSY = 2'b01,
    DONE = 2'b10
  } state_t;
  localparam logic [3:0] BE_LANE0 = 4'b0001;
  localparam logic [3:0] BE_LANE1 = 4'b0010;
  localparam logic [3:0] BE_LANE2 = 4'b0100;
  localparam logic [3:0] BE_LANE3 = 4'b1000;
  localparam logic [3:0] BE_WORD  = 4'b1111;
endpackage

// File: rtl/dmem_ctrl_byte_lane.sv
// byte_lane: store replication, byte enables and load byte extraction
// Ports: lane = addr[1:0], byte_en = byte access, store = write access,
//        wdata_in/rdata_in raw data in, be/wdata/rdata steered results out.
module byte_lane
  import dmem_pkg::*;
(
  input  logic [1:0]  lane,
  input  logic        byte_en,
  input  logic        store,
  input  logic [31:0] wdata_in,
  input  logic [31:0] rdata_in,
  output logic [3:0]  be,
  output logic [31:0] wdata,
  output logic [31:0] rdata
);
  always_comb begin
    be    = (store & byte_en) ? BE_LANE0 << lane : BE_WORD;
    wdata = byte_en ? {4{wdata_in[7:0]}} : wdata_in;
    rdata = byte_en ? {24'b0, rdata_in[{lane, 3'b000} +: 8]} : rdata_in;
  end
endmodule

// File: rtl/dmem_ctrl.sv
// dmem_ctrl: M-stage data memory controller with req/ready handshake and stall
// Ports: clk/reset (async active-low); MemWriteM/MemReadM/ByteM/ALUOutM/WriteDataM
//        from the M stage; ReadDataM/StallM/align_err/bus_err to the pipeline;
//        mem_req/mem_we/mem_addr/mem_be/mem_wdata/mem_rdata/mem_ready to memory.
module dmem_ctrl
  import dmem_pkg::*;
#(
  parameter int TIMEOUT = 255,
  parameter int CNT_W   = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MemWriteM,
  input  logic        MemReadM,
  input  logic        ByteM,
  input  logic [31:0] ALUOutM,
  input  logic [31:0] WriteDataM,
  output logic [31:0] ReadDataM,
  output logic        StallM,
  output logic        align_err,
  output logic        bus_err,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ready
);
  state_t           state, state_nx;
  logic [CNT_W-1:0] cnt;
  logic [31:0]      cap, lane_rdata;
  logic             err_q, access, aligned, load, issue, busy, hit, timeout;
  assign access  = MemWriteM | MemReadM;
  assign aligned = ByteM | (ALUOutM[1:0] == 2'b00);
  assign load    = MemReadM & ~MemWriteM;
  // Outputs are gated by reset so a request drops the instant reset asserts.
  assign issue     = reset & (state == IDLE) & access & aligned;
  assign busy      = reset & (state == BUSY);
  assign mem_req   = issue | busy;
  assign StallM    = mem_req;
  assign hit       = mem_req & mem_ready;
  // Fires on the TIMEOUT-th BUSY cycle without ready; a late ready still wins.
  assign timeout   = busy & ~mem_ready & (cnt == CNT_W'(TIMEOUT - 1));
  assign align_err = reset & (state == IDLE) & access & ~aligned;
  assign bus_err   = err_q;
  assign mem_we    = MemWriteM;
  assign mem_addr  = {ALUOutM[31:2], 2'b00};
  // Data is forwarded on the ready cycle too, giving a one-cycle minimum stall.
  assign ReadDataM = (state == DONE) ? cap : (hit & load) ? lane_rdata : 32'b0;
  byte_lane u_lane (
    .lane    (ALUOutM[1:0]),
    .byte_en (ByteM),
    .store   (MemWriteM),
    .wdata_in(WriteDataM),
    .rdata_in(mem_rdata),
    .be      (mem_be),
    .wdata   (mem_wdata),
    .rdata   (lane_rdata)
  );
  always_comb begin
    state_nx = state;
    state_nx = (state == DONE) ? IDLE : (hit | timeout) ? DONE : issue ? BUSY : state;
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      cnt   <= '0;
      cap   <= '0;
      err_q <= 1'b0;
    end else begin
      state <= state_nx;
      err_q <= timeout;
      if (issue & ~mem_ready) cnt <= '0;
      else if (busy && cnt != '1) cnt <= cnt + 1'b1;
      if (hit) cap <= load ? lane_rdata : 32'b0;
      else if (timeout) cap <= 32'b0;
    end
  end
endmodule

// File: tb/tb_dmem_ctrl.sv
// tb_dmem_ctrl: directed and randomized checks of dmem_ctrl against a behavioural model
module tb_dmem_ctrl;
  localparam int T = 4;
  logic        clk = 0, reset = 0;
  logic        MemWriteM = 0, MemReadM = 0, ByteM = 0, mem_ready = 0;
  logic [31:0] ALUOutM = 0, WriteDataM = 0, mem_rdata = 0;
  logic [31:0] ReadDataM, mem_addr, mem_wdata;
  logic        StallM, align_err, bus_err, mem_req, mem_we;
  logic [3:0]  mem_be;
  int tests = 0, fails = 0;
  int          o_stalls;
  logic [31:0] o_wd, o_addr, o_hit, o_done, o_idle_rd;
  logic [3:0]  o_be;
  logic        o_we, o_aerr, o_req, o_stable, o_berr, o_req_done, o_berr2, o_idle_stall;

  dmem_ctrl #(.TIMEOUT(T), .CNT_W(8)) dut (
    .clk(clk), .reset(reset), .MemWriteM(MemWriteM), .MemReadM(MemReadM), .ByteM(ByteM),
    .ALUOutM(ALUOutM), .WriteDataM(WriteDataM), .ReadDataM(ReadDataM), .StallM(StallM),
    .align_err(align_err), .bus_err(bus_err), .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_be(mem_be), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .mem_ready(mem_ready)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] model_rd(input logic we, input logic bt, input logic [31:0] a,
                                           input logic [31:0] rd);
    if (we) return 32'b0;
    return bt ? (rd >> (8 * a[1:0])) & 32'hFF : rd;
  endfunction

  // Drives one M-stage access; ready arrives wait_n cycles after issue. Only observes.
  task automatic run(input logic we, input logic re, input logic bt, input logic [31:0] a,
                     input logic [31:0] wd, input logic [31:0] rd, input int wait_n);
    int cyc;
    @(negedge clk);
    MemWriteM = we; MemReadM = re; ByteM = bt; ALUOutM = a; WriteDataM = wd;
    mem_rdata = rd; mem_ready = (wait_n == 0);
    #1;
    o_be = mem_be; o_wd = mem_wdata; o_addr = mem_addr; o_we = mem_we;
    o_aerr = align_err; o_req = mem_req; o_stalls = 0; o_stable = 1; o_hit = 0; cyc = 0;
    while (StallM && cyc < 40) begin
      o_stalls++;
      if (mem_be !== o_be || mem_wdata !== o_wd || mem_addr !== o_addr || mem_we !== o_we || mem_req !== 1'b1)
        o_stable = 0;
      if (mem_ready) o_hit = ReadDataM;
      @(negedge clk);
      cyc++;
      mem_ready = (cyc == wait_n);
      #1;
    end
    o_done = ReadDataM; o_berr = bus_err; o_req_done = mem_req;
    @(negedge clk);
    MemWriteM = 0; MemReadM = 0; mem_ready = 0;
    #1;
    o_berr2 = bus_err; o_idle_rd = ReadDataM; o_idle_stall = StallM;
  endtask

  task automatic test_reset;
    reset = 0; MemReadM = 1; ALUOutM = 32'h100; mem_ready = 1;
    #7;
    tests++; if (mem_req !== 0) begin fails++; $display("FAIL rst_req got=%b exp=0", mem_req); end
    tests++; if (StallM !== 0) begin fails++; $display("FAIL rst_stall got=%b exp=0", StallM); end
    tests++; if ({align_err, bus_err} !== 2'b00) begin fails++; $display("FAIL rst_err got=%b exp=00", {align_err, bus_err}); end
    tests++; if (ReadDataM !== 0) begin fails++; $display("FAIL rst_rd got=%h exp=0", ReadDataM); end
    @(negedge clk); reset = 1; MemReadM = 0; mem_ready = 0;
    @(negedge clk); #1;
    tests++; if (StallM !== 0) begin fails++; $display("FAIL rst_idle_stall got=%b exp=0", StallM); end
  endtask

  task automatic test_word_load;
    run(0, 1, 0, 32'h100, 0, 32'hDEADBEEF, 3);
    tests++; if (o_stalls !== 4) begin fails++; $display("FAIL wl_stalls got=%0d exp=4", o_stalls); end
    tests++; if (o_done !== 32'hDEADBEEF) begin fails++; $display("FAIL wl_done got=%h exp=deadbeef", o_done); end
    tests++; if (o_hit !== 32'hDEADBEEF) begin fails++; $display("FAIL wl_hit got=%h exp=deadbeef", o_hit); end
    tests++; if (o_addr !== 32'h100 || o_stable !== 1) begin fails++; $display("FAIL wl_addr got=%h stable=%b exp=100/1", o_addr, o_stable); end
    tests++; if (o_be !== 4'hF || o_we !== 0) begin fails++; $display("FAIL wl_be got=%h/%b exp=f/0", o_be, o_we); end
    tests++; if (o_req_done !== 0 || o_idle_rd !== 0) begin fails++; $display("FAIL wl_done_req got=%b/%h exp=0/0", o_req_done, o_idle_rd); end
  endtask

  task automatic test_strb;
    run(1, 0, 1, 32'h203, 32'h123456AB, 32'hFFFFFFFF, 0);
    tests++; if (o_be !== 4'b1000) begin fails++; $display("FAIL strb_be got=%b exp=1000", o_be); end
    tests++; if (o_wd !== 32'hABABABAB) begin fails++; $display("FAIL strb_wd got=%h exp=abababab", o_wd); end
    tests++; if (o_addr !== 32'h200 || o_we !== 1) begin fails++; $display("FAIL strb_addr got=%h/%b exp=200/1", o_addr, o_we); end
    tests++; if (o_stalls !== 1) begin fails++; $display("FAIL strb_stalls got=%0d exp=1", o_stalls); end
    tests++; if (o_done !== 0) begin fails++; $display("FAIL strb_rd got=%h exp=0", o_done); end
  endtask

  task automatic test_ldrb;
    run(0, 1, 1, 32'h302, 0, 32'h11C32244, 1);
    tests++; if (o_done !== 32'h000000C3) begin fails++; $display("FAIL ldrb_rd got=%h exp=000000c3", o_done); end
    tests++; if (o_be !== 4'hF) begin fails++; $display("FAIL ldrb_be got=%h exp=f", o_be); end
    tests++; if (o_stalls !== 2) begin fails++; $display("FAIL ldrb_stalls got=%0d exp=2", o_stalls); end
  endtask

  task automatic test_misaligned;
    run(1, 0, 0, 32'h401, 32'h55AA55AA, 0, 0);
    tests++; if (o_aerr !== 1) begin fails++; $display("FAIL mis_aerr got=%b exp=1", o_aerr); end
    tests++; if (o_req !== 0 || o_stalls !== 0) begin fails++; $display("FAIL mis_req got=%b stalls=%0d exp=0/0", o_req, o_stalls); end
    tests++; if (o_done !== 0) begin fails++; $display("FAIL mis_rd got=%h exp=0", o_done); end
  endtask

  task automatic test_timeout;
    run(0, 1, 0, 32'h600, 0, 32'h12345678, 1000);
    tests++; if (o_stalls !== 1 + T) begin fails++; $display("FAIL to_stalls got=%0d exp=%0d", o_stalls, 1 + T); end
    tests++; if (o_berr !== 1) begin fails++; $display("FAIL to_berr got=%b exp=1", o_berr); end
    tests++; if (o_done !== 0) begin fails++; $display("FAIL to_rd got=%h exp=0", o_done); end
    tests++; if (o_berr2 !== 0 || o_idle_stall !== 0) begin fails++; $display("FAIL to_idle got=%b/%b exp=0/0", o_berr2, o_idle_stall); end
  endtask

  task automatic test_reset_busy;
    @(negedge clk); MemReadM = 1; MemWriteM = 0; ByteM = 0; ALUOutM = 32'h500; mem_ready = 0;
    repeat (2) @(negedge clk);
    #1;
    tests++; if (mem_req !== 1) begin fails++; $display("FAIL rb_busy got=%b exp=1", mem_req); end
    #2 reset = 0; MemReadM = 0;
    #1;
    tests++; if (mem_req !== 0 || StallM !== 0) begin fails++; $display("FAIL rb_drop got=%b/%b exp=0/0", mem_req, StallM); end
    @(negedge clk); reset = 1;
    @(negedge clk); mem_ready = 1; mem_rdata = 32'hCAFEF00D;
    #1;
    tests++; if (StallM !== 0 || ReadDataM !== 0) begin fails++; $display("FAIL rb_late got=%b/%h exp=0/0", StallM, ReadDataM); end
    @(negedge clk); mem_ready = 0;
    #1;
    tests++; if (ReadDataM !== 0 || bus_err !== 0) begin fails++; $display("FAIL rb_nodone got=%h/%b exp=0/0", ReadDataM, bus_err); end
  endtask

  task automatic test_random;
    for (int i = 0; i < 40; i++) begin
      logic we, re, bt, mis, to;
      logic [31:0] a, wd, rd, exp_rd;
      logic [3:0] exp_be;
      int k, w, exp_st;
      k = $urandom_range(0, 2);
      we = (k != 0); re = (k != 1); bt = $urandom_range(0, 1);
      a = $urandom; wd = $urandom; rd = $urandom; w = $urandom_range(0, 6);
      if (!bt && $urandom_range(0, 3) != 0) a[1:0] = 2'b00;
      mis = !bt && a[1:0] != 2'b00;
      to = !mis && w > T;
      exp_st = mis ? 0 : (to ? 1 + T : 1 + w);
      exp_rd = (mis || to) ? 32'b0 : model_rd(we, bt, a, rd);
      exp_be = (we && bt) ? 4'(1 << a[1:0]) : 4'hF;
      run(we, re, bt, a, wd, rd, w);
      tests++; if (o_stalls !== exp_st) begin fails++; $display("FAIL rnd%0d_stalls got=%0d exp=%0d", i, o_stalls, exp_st); end
      tests++; if (o_done !== exp_rd || (!mis && o_hit !== exp_rd)) begin fails++; $display("FAIL rnd%0d_rd got=%h/%h exp=%h", i, o_done, o_hit, exp_rd); end
      tests++; if (o_berr !== to || o_aerr !== mis) begin fails++; $display("FAIL rnd%0d_err got=%b/%b exp=%b/%b", i, o_berr, o_aerr, to, mis); end
      tests++; if (o_req_done !== 0 || o_idle_stall !== 0 || o_berr2 !== 0) begin fails++; $display("FAIL rnd%0d_end got=%b%b%b exp=000", i, o_req_done, o_idle_stall, o_berr2); end
      if (!mis) begin
        tests++; if (o_be !== exp_be || o_we !== we || o_addr !== {a[31:2], 2'b00} || o_stable !== 1) begin
          fails++; $display("FAIL rnd%0d_bus got=%h/%b/%h/%b exp=%h/%b/%h/1", i, o_be, o_we, o_addr, o_stable, exp_be, we, {a[31:2], 2'b00});
        end
        if (we) begin
          tests++; if (o_wd !== (bt ? {4{wd[7:0]}} : wd)) begin fails++; $display("FAIL rnd%0d_wd got=%h", i, o_wd); end
        end
      end
    end
  endtask

  initial begin
    test_reset;
    test_word_load;
    test_strb;
    test_ldrb;
    test_misaligned;
    test_timeout;
    test_reset_busy;
    test_random;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
